interval_timer: RTL and testbench

- Memory-mapped programmable timer that is an interrupt source for the CPU interrupt controller.
- Its int_out drives one bit of the controller's interrupts vector.
- The controller synchronises that line and detects its rising edge, so int_out is a stretched level pulse, not a single-cycle strobe.
- The CPU configures the block over the standard start/done MMIO handshake.

---
 rtl/interval_timer_pkg.sv | 31 +++
 rtl/irq_pulse_stretcher.sv | 29 ++
 rtl/interval_timer.sv | 132 +++++++++++++
 tb/tb_interval_timer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_pkg.sv
// Shared register map, CTRL bit layout and state encoding for the interval timer.
package interval_timer_pkg;

  localparam logic [1:0] ADDR_RELOAD   = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_CTRL     = 2'd2;
  localparam logic [1:0] ADDR_COUNT    = 2'd3;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_EXPIRED  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Field order matches the CTRL bit indices above (en is bit 0).
  typedef struct packed {
    logic expired;
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(ctrl_t c);
    return 32'(c);
  endfunction

endpackage

// File: rtl/irq_pulse_stretcher.sv
// Holds its output high for PULSE_CYCLES clocks after each trigger; a new trigger restarts the count.
module irq_pulse_stretcher #(
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // pulse is high exactly while cnt is nonzero, registered alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (trigger) begin
      cnt   <= CNT_W'(PULSE_CYCLES);
      pulse <= 1'b1;
    end else if (cnt != '0) begin
      cnt   <= cnt - CNT_W'(1);
      pulse <= (cnt != CNT_W'(1));
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Memory-mapped down-counting timer with prescaler; raises a stretched interrupt pulse on expiry.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned PRESCALE_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        done,
  output logic        int_out
);

  state_e                state, state_d;
  ctrl_t                 ctrl, ctrl_d;
  logic [31:0]           reload, reload_d;
  logic [31:0]           count, count_d;
  logic [PRESCALE_W-1:0] prescale, prescale_d;
  logic [PRESCALE_W-1:0] psc, psc_d;
  logic                  tick_c;
  logic                  expire_c;
  logic                  trig_c;
  logic [31:0]           rdata_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      reload   <= '0;
      count    <= '0;
      prescale <= '0;
      psc      <= '0;
    end else begin
      state    <= state_d;
      ctrl     <= ctrl_d;
      reload   <= reload_d;
      count    <= count_d;
      prescale <= prescale_d;
      psc      <= psc_d;
    end
  end

  // Counting first, then a bus write overrides it so written CTRL bits win a same-cycle expiry.
  always_comb begin
    state_d    = state;
    ctrl_d     = ctrl;
    reload_d   = reload;
    count_d    = count;
    prescale_d = prescale;
    psc_d      = psc;
    expire_c   = 1'b0;
    tick_c     = (state == ST_RUN) && (psc == prescale);

    if (state == ST_RUN) begin
      psc_d = tick_c ? '0 : psc + PRESCALE_W'(1);
      if (tick_c) begin
        if (count != '0) begin
          count_d = count - 32'd1;
        end else begin
          expire_c       = 1'b1;
          ctrl_d.expired = 1'b1;
          if (ctrl.periodic) begin
            count_d = reload;
          end else begin
            ctrl_d.en = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
    end

    if (start && we) begin
      case (addr)
        ADDR_RELOAD:   reload_d   = data;
        ADDR_PRESCALE: prescale_d = data[PRESCALE_W-1:0];
        ADDR_CTRL: begin
          ctrl_d.en       = data[CTRL_EN];
          ctrl_d.periodic = data[CTRL_PERIODIC];
          ctrl_d.irq_en   = data[CTRL_IRQ_EN];
          // a concurrent expiry keeps the sticky flag set despite write-1-to-clear
          if (data[CTRL_EXPIRED] && !expire_c) ctrl_d.expired = 1'b0;
          if (data[CTRL_EN]) begin
            state_d = ST_RUN;
            count_d = reload;
            psc_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_c = '0;
    case (addr)
      ADDR_RELOAD:   rdata_c = reload;
      ADDR_PRESCALE: rdata_c = 32'(prescale);
      ADDR_CTRL:     rdata_c = ctrl_word(ctrl);
      ADDR_COUNT:    rdata_c = count;
      default:       rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      q    <= '0;
    end else begin
      done <= start;
      q    <= (start && !we) ? rdata_c : '0;
    end
  end

  assign trig_c = expire_c && ctrl.irq_en;

  irq_pulse_stretcher #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_stretch (
    .clk     (clk),
    .reset   (reset),
    .trigger (trig_c),
    .pulse   (int_out)
  );

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: register table, directed corner sequences, randomized runs vs. an arithmetic timeline model.
module tb_interval_timer;

  localparam int unsigned PULSE_CYCLES = 4;
  localparam int unsigned PRESCALE_W   = 16;
  localparam int          PULSE        = 4;

  localparam logic [1:0] A_RELOAD   = 2'd0;
  localparam logic [1:0] A_PRESCALE = 2'd1;
  localparam logic [1:0] A_CTRL     = 2'd2;
  localparam logic [1:0] A_COUNT    = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] data = '0;
  logic [31:0] q;
  logic        done;
  logic        int_out;

  interval_timer #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .PRESCALE_W  (PRESCALE_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .we      (we),
    .addr    (addr),
    .data    (data),
    .q       (q),
    .done    (done),
    .int_out (int_out)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Timeline model: after an enabling write at edge m_t0, expiries land at m_t0 + k*m_L.
  bit          m_run, m_periodic, m_irq, m_exp_flag;
  int          m_t0, m_L, m_R, m_P, m_hold;
  logic [31:0] m_frozen, m_reg_reload, m_reg_prescale;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_periodic = 0; m_irq = 0; m_exp_flag = 0;
    m_t0 = 0; m_L = 1; m_R = 0; m_P = 0; m_hold = -1;
    m_frozen = '0; m_reg_reload = '0; m_reg_prescale = '0;
  endfunction

  function automatic bit expiry_at(int t);
    int rel = t - m_t0;
    if (!m_run || rel < m_L) return 1'b0;
    return m_periodic ? (rel % m_L == 0) : (rel == m_L);
  endfunction

  // End edge of the pulse window of the latest interrupting expiry at or before t, or -1.
  function automatic int last_end(int t);
    int rel = t - m_t0;
    if (!m_run || !m_irq || rel < m_L) return -1;
    if (!m_periodic) return m_t0 + m_L + PULSE - 1;
    return m_t0 + (rel / m_L) * m_L + PULSE - 1;
  endfunction

  function automatic bit int_at(int t);
    return (t <= m_hold) || (last_end(t) >= t);
  endfunction

  function automatic logic [31:0] count_at(int t);
    int rel = t - m_t0;
    if (!m_run) return m_frozen;
    if (!m_periodic) return (rel >= m_L) ? 32'd0 : 32'(m_R - rel / (m_P + 1));
    return 32'(m_R - (rel % m_L) / (m_P + 1));
  endfunction

  function automatic logic [31:0] ctrl_at(int t);
    int rel = t - m_t0;
    bit en, ex;
    en = m_run && (m_periodic || rel < m_L);
    ex = m_exp_flag || (m_run && rel >= m_L);
    return {28'd0, ex, m_irq, m_periodic, en};
  endfunction

  function automatic void model_ctrl_write(int t, logic [31:0] d);
    int  e = last_end(t);
    bit  old_exp = ctrl_at(t)[3];
    bit  exp_now = expiry_at(t);
    if (e > m_hold) m_hold = e;
    m_frozen   = count_at(t);
    m_exp_flag = d[3] ? exp_now : old_exp;
    m_periodic = d[1];
    m_irq      = d[2];
    if (d[0]) begin
      m_run = 1;
      m_t0  = t;
      m_R   = int'(m_reg_reload);
      m_P   = int'(m_reg_prescale);
      m_L   = (m_R + 1) * (m_P + 1);
    end else begin
      m_run = 0;
    end
  endfunction

  function automatic string rd_name(logic [1:0] a);
    case (a)
      A_RELOAD:   return "rd_reload";
      A_PRESCALE: return "rd_prescale";
      A_CTRL:     return "rd_ctrl";
      default:    return "rd_count";
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (chk_en) check("int_out", 32'(int_out), 32'(int_at(edge_n)));
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    start = 1'b1; we = 1'b1; addr = a; data = d;
    step();
    check("done_wr", 32'(done), 32'd1);
    case (a)
      A_RELOAD:   m_reg_reload = d;
      A_PRESCALE: m_reg_prescale = {16'd0, d[15:0]};
      A_CTRL:     model_ctrl_write(edge_n, d);
      default:    ;
    endcase
    start = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    logic [31:0] e;
    int t;
    start = 1'b1; we = 1'b0; addr = a; data = $urandom;
    step();
    t = edge_n - 1;
    case (a)
      A_RELOAD:   e = m_reg_reload;
      A_PRESCALE: e = m_reg_prescale;
      A_CTRL:     e = ctrl_at(t);
      default:    e = count_at(t);
    endcase
    check("done_rd", 32'(done), 32'd1);
    check(rd_name(a), q, e);
    v = q;
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk_en = 1'b1;
    check("rst_int", 32'(int_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", q, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    vec_t        vecs[5];
    logic [31:0] v, v1, v2;
    int          t0, t2, t3;

    model_reset();
    do_reset();

    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v);
      check("rst_reg", v, 32'd0);
    end

    // Register write/read-back table (timer stays idle: no EN in any CTRL write)
    vecs[0] = '{A_RELOAD,   32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{A_PRESCALE, 32'h00012345, 32'h00002345};
    vecs[2] = '{A_CTRL,     32'hFFFFFFF6, 32'h00000006};
    vecs[3] = '{A_COUNT,    32'h00000055, 32'h00000000};
    vecs[4] = '{A_CTRL,     32'h00000000, 32'h00000000};
    for (int i = 0; i < 5; i++) begin
      bus_write(vecs[i].a, vecs[i].wd);
      bus_read(vecs[i].a, v);
      check("table", v, vecs[i].exp);
    end

    // One-shot with prescale
    bus_write(A_RELOAD, 32'd3);
    bus_write(A_PRESCALE, 32'd1);
    bus_write(A_CTRL, 32'h5);
    t0 = edge_n;
    for (int i = 1; i <= 13; i++) begin
      step();
      check("oneshot_int", 32'(int_out), 32'(i >= 8 && i <= 11));
    end
    bus_read(A_CTRL, v);
    check("oneshot_ctrl", v, 32'hC);
    bus_read(A_COUNT, v);
    check("oneshot_count", v, 32'd0);

    // Periodic
    bus_write(A_RELOAD, 32'd9);
    bus_write(A_PRESCALE, 32'd0);
    bus_write(A_CTRL, 32'h7);
    t0 = edge_n;
    for (int i = 1; i <= 35; i++) begin
      step();
      check("periodic_int", 32'(int_out), 32'(i >= 10 && (i % 10) <= 3));
    end
    bus_write(A_CTRL, 32'h8);
    bus_read(A_CTRL, v);
    check("periodic_clear", v, 32'h0);

    // IRQ masked, back-to-back reads
    bus_write(A_RELOAD, 32'd2);
    bus_write(A_CTRL, 32'h1);
    step();
    bus_read(A_CTRL, v);
    check("masked_ctrl_a", v, 32'h1);
    bus_read(A_CTRL, v);
    check("masked_ctrl_b", v, 32'h1);
    bus_read(A_CTRL, v);
    check("masked_ctrl_c", v, 32'h8);
    check("masked_int", 32'(int_out), 32'd0);

    // Bus handshake while running
    bus_write(A_RELOAD, 32'd100);
    bus_write(A_CTRL, 32'h1);
    repeat (5) step();
    bus_read(A_COUNT, v1);
    step();
    check("done_low", 32'(done), 32'd0);
    check("q_idle", q, 32'd0);
    step();
    bus_read(A_COUNT, v2);
    check("count_dec", 32'(v2 < v1), 32'd1);
    bus_write(A_COUNT, 32'h1234);
    bus_read(A_COUNT, v);
    check("count_ro", 32'(v != 32'h1234), 32'd1);

    // Collisions with expiry
    bus_write(A_RELOAD, 32'd5);
    bus_write(A_CTRL, 32'h7);
    t0 = edge_n;
    wait_edge(t0 + 11);
    bus_write(A_CTRL, 32'h8);
    bus_read(A_CTRL, v);
    check("coll_clear", v, 32'h8);
    wait_edge(t0 + 20);
    bus_write(A_CTRL, 32'h7);
    t2 = edge_n;
    wait_edge(t2 + 5);
    bus_write(A_CTRL, 32'h5);
    t3 = edge_n;
    bus_read(A_COUNT, v);
    check("coll_reload", v, 32'd5);
    wait_edge(t3 + 3);
    step();
    check("coll_gap_a", 32'(int_out), 32'd0);
    step();
    check("coll_gap_b", 32'(int_out), 32'd0);
    step();
    check("coll_next", 32'(int_out), 32'd1);

    // Reset mid-pulse
    bus_write(A_RELOAD, 32'd1);
    bus_write(A_CTRL, 32'h7);
    t0 = edge_n;
    wait_edge(t0 + 3);
    check("pre_rst_int", 32'(int_out), 32'd1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_int", 32'(int_out), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v);
      check("post_rst_reg", v, 32'd0);
    end

    // Randomized scenarios against the timeline model
    for (int s = 0; s < 25; s++) begin
      int n;
      bus_write(A_CTRL, {28'd0, 1'($urandom_range(0, 1)), 3'd0});
      bus_write(A_RELOAD, 32'($urandom_range(0, 12)));
      bus_write(A_PRESCALE, 32'($urandom_range(0, 3)));
      bus_write(A_CTRL, {28'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b1});
      n = $urandom_range(5, 50);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) bus_read(2'($urandom_range(0, 3)), v);
        else step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
